// File: rtl/bus_grant_mux_if.sv
// ----------------------------------------------------------------------------
// bus_grant_mux_if : arbiter grant, per-master command and shared slave bundle
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bus_grant_mux_if #(
   parameter int NumRequests = 8,
   parameter int AddrWidth   = 32,
   parameter int DataWidth   = 32
);
   localparam int ENC_WIDTH = $clog2(NumRequests) + 1;

   logic [NumRequests-1:0]           grant;
   logic [ENC_WIDTH-1:0]             grant_enc;
   logic                             hold;
   logic [NumRequests-1:0]           m_req;
   logic [NumRequests-1:0]           m_we;
   logic [NumRequests-1:0]           m_last;
   logic [NumRequests*AddrWidth-1:0] m_adr;
   logic [NumRequests*DataWidth-1:0] m_dat;
   logic [NumRequests-1:0]           m_ack;
   logic [NumRequests-1:0]           m_err;
   logic [DataWidth-1:0]             m_dati;
   logic                             s_cyc;
   logic                             s_stb;
   logic                             s_we;
   logic [AddrWidth-1:0]             s_adr;
   logic [DataWidth-1:0]             s_dato;
   logic                             s_ack;
   logic [DataWidth-1:0]             s_dati;

   // master: the mux, which owns the shared slave port; slave: everything around it
   modport master (
      input  grant, grant_enc, m_req, m_we, m_last, m_adr, m_dat, s_ack, s_dati,
      output hold, m_ack, m_err, m_dati, s_cyc, s_stb, s_we, s_adr, s_dato
   );

   modport slave (
      output grant, grant_enc, m_req, m_we, m_last, m_adr, m_dat, s_ack, s_dati,
      input  hold, m_ack, m_err, m_dati, s_cyc, s_stb, s_we, s_adr, s_dato
   );
endinterface

`default_nettype wire

// File: rtl/bus_grant_mux.sv
// ----------------------------------------------------------------------------
// bus_grant_mux : latches the arbiter winner and routes it to one slave port
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_grant_mux #(
   parameter int NumRequests   = 8,
   parameter int AddrWidth     = 32,
   parameter int DataWidth     = 32,
   parameter int BurstMax      = 16,
   parameter int TimeoutCycles = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ce,
   bus_grant_mux_if.master bus
);
   localparam int OW = (NumRequests > 1) ? $clog2(NumRequests) : 1;
   localparam int EW = $clog2(NumRequests) + 1;
   localparam int BW = $clog2(BurstMax + 1);

   localparam logic [1:0]    ST_IDLE    = 2'd0;
   localparam logic [1:0]    ST_ACTIVE  = 2'd1;
   localparam logic [1:0]    ST_RELEASE = 2'd2;
   localparam logic [EW-1:0] NREQ       = EW'(NumRequests);
   localparam logic [BW-1:0] BURST_LAST = BW'(BurstMax);
   localparam logic [15:0]   TMO_LAST   = 16'(TimeoutCycles - 1);

   logic [1:0]    state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;
   logic [15:0]   tmo_cnt_q, tmo_cnt_d;

   logic                 own_req, own_we, own_last, grant_req;
   logic [AddrWidth-1:0] own_adr;
   logic [DataWidth-1:0] own_dat;
   logic                 start, active, tmo_hit;
   logic [BW-1:0]        beat_inc;

   always_comb begin
      own_req   = 1'b0;
      own_we    = 1'b0;
      own_last  = 1'b0;
      own_adr   = '0;
      own_dat   = '0;
      grant_req = 1'b0;
      for (int i = 0; i < NumRequests; i++) begin
         if (owner_q == OW'(i)) begin
            own_req  = bus.m_req[i];
            own_we   = bus.m_we[i];
            own_last = bus.m_last[i];
            own_adr  = bus.m_adr[i*AddrWidth +: AddrWidth];
            own_dat  = bus.m_dat[i*DataWidth +: DataWidth];
         end
         if (bus.grant_enc == EW'(i)) begin
            grant_req = bus.m_req[i];
         end
      end
   end

   assign active   = (state_q == ST_ACTIVE);
   assign start    = (|bus.grant) && (bus.grant_enc < NREQ) && grant_req;
   assign tmo_hit  = (tmo_cnt_q == TMO_LAST);
   assign beat_inc = beat_cnt_q + BW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         tmo_cnt_q  <= '0;
      end else if (ce) begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

   // Ack outranks a dropped request and the timeout boundary
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               owner_d    = bus.grant_enc[OW-1:0];
               beat_cnt_d = '0;
               tmo_cnt_d  = '0;
               state_d    = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (bus.s_ack) begin
               beat_cnt_d = beat_inc;
               tmo_cnt_d  = '0;
               if (own_last || (beat_inc == BURST_LAST)) begin
                  state_d = ST_RELEASE;
               end
            end else if (!own_req || tmo_hit) begin
               state_d = ST_RELEASE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Pulses are suppressed while stalled or while a reset aborts the beat
   always_comb begin
      bus.hold   = active;
      bus.s_cyc  = active;
      bus.s_stb  = active && own_req;
      bus.s_we   = active ? own_we  : 1'b0;
      bus.s_adr  = active ? own_adr : '0;
      bus.s_dato = active ? own_dat : '0;
      bus.m_dati = bus.s_dati;
      bus.m_ack  = '0;
      bus.m_err  = '0;
      for (int i = 0; i < NumRequests; i++) begin
         if (active && ce && !rst && (owner_q == OW'(i))) begin
            bus.m_ack[i] = bus.s_ack;
            bus.m_err[i] = !bus.s_ack && own_req && tmo_hit;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_grant_mux.sv
// ----------------------------------------------------------------------------
// tb_bus_grant_mux : directed stimulus checked against a cycle model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bus_grant_mux;
   localparam int N   = 8;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int BURST = 4;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   bus_grant_mux_if #(.NumRequests(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

   bus_grant_mux #(
      .NumRequests(N), .AddrWidth(AW), .DataWidth(DW),
      .BurstMax(BURST), .TimeoutCycles(TMO)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Model: who owns the bus, whether the release gap is pending, beats and idle waits
   int own     = -1;
   bit rel     = 1'b0;
   int beats   = 0;
   int waited  = 0;

   always @(posedge clk) begin
      if (rst) begin
         own <= -1;
         rel <= 1'b0;
      end else if (ce) begin
         if (rel) begin
            rel <= 1'b0;
         end else if (own < 0) begin
            if (bus.grant != 0 && int'(bus.grant_enc) < N && bus.m_req[int'(bus.grant_enc)]) begin
               own    <= int'(bus.grant_enc);
               beats  <= 0;
               waited <= 0;
            end
         end else if (bus.s_ack) begin
            beats  <= beats + 1;
            waited <= 0;
            if (bus.m_last[own] || beats + 1 == BURST) begin
               own <= -1;
               rel <= 1'b1;
            end
         end else if (!bus.m_req[own] || waited == TMO - 1) begin
            own <= -1;
            rel <= 1'b1;
         end else begin
            waited <= waited + 1;
         end
      end
   end

   function automatic logic [N-1:0] exp_ack();
      exp_ack = '0;
      if (own >= 0 && ce && !rst && bus.s_ack) exp_ack[own] = 1'b1;
   endfunction

   function automatic logic [N-1:0] exp_err();
      exp_err = '0;
      if (own >= 0 && ce && !rst && !bus.s_ack && bus.m_req[own] && waited == TMO - 1)
         exp_err[own] = 1'b1;
   endfunction

   function automatic logic exp_stb();
      exp_stb = (own >= 0) ? bus.m_req[own] : 1'b0;
   endfunction

   function automatic logic exp_we();
      exp_we = (own >= 0) ? bus.m_we[own] : 1'b0;
   endfunction

   function automatic logic [AW-1:0] exp_adr();
      exp_adr = (own >= 0) ? bus.m_adr[own*AW +: AW] : '0;
   endfunction

   function automatic logic [DW-1:0] exp_dat();
      exp_dat = (own >= 0) ? bus.m_dat[own*DW +: DW] : '0;
   endfunction

   always @(negedge clk) begin
      chk("mdl_hold",   bus.hold,   own >= 0);
      chk("mdl_s_cyc",  bus.s_cyc,  own >= 0);
      chk("mdl_s_stb",  bus.s_stb,  exp_stb());
      chk("mdl_s_we",   bus.s_we,   exp_we());
      chk("mdl_s_adr",  bus.s_adr,  exp_adr());
      chk("mdl_s_dato", bus.s_dato, exp_dat());
      chk("mdl_m_ack",  bus.m_ack,  exp_ack());
      chk("mdl_m_err",  bus.m_err,  exp_err());
      chk("mdl_m_dati", bus.m_dati, bus.s_dati);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input bit req, input bit we, input bit last,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.m_req[i]          = req;
      bus.m_we[i]           = we;
      bus.m_last[i]         = last;
      bus.m_adr[i*AW +: AW] = a;
      bus.m_dat[i*DW +: DW] = d;
   endtask

   task automatic give(input int i);
      bus.grant     = '0;
      bus.grant[i]  = 1'b1;
      bus.grant_enc = 4'(i);
   endtask

   task automatic clear();
      bus.m_req     = '0;
      bus.m_we      = '0;
      bus.m_last    = '0;
      bus.grant     = '0;
      bus.grant_enc = '0;
      bus.s_ack     = 1'b0;
   endtask

   task automatic settle();
      clear();
      tick();
      tick();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int cnt;
      clear();
      bus.m_adr  = '0;
      bus.m_dat  = '0;
      bus.s_dati = '0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_hold",  bus.hold,  0);
      chk("rst_s_cyc", bus.s_cyc, 0);
      chk("rst_m_ack", bus.m_ack, 0);
      chk("rst_s_adr", bus.s_adr, 0);
      rst = 1'b0;
      tick();

      // single read by master 2
      drive(2, 1, 0, 1, 32'h1000_0200, 32'h0);
      give(2);
      @(negedge clk);
      chk("t1_idle_hold", bus.hold, 0);
      tick();
      @(negedge clk);
      chk("t1_act_hold", bus.hold, 1);
      chk("t1_s_adr", bus.s_adr, 32'h1000_0200);
      chk("t1_no_ack", bus.m_ack, 0);
      tick();
      bus.s_ack  = 1'b1;
      bus.s_dati = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t1_m_ack", bus.m_ack, 8'h04);
      chk("t1_m_dati", bus.m_dati, 32'hDEAD_BEEF);
      chk("t1_hold2", bus.hold, 1);
      tick();
      clear();
      @(negedge clk);
      chk("t1_rel_cyc", bus.s_cyc, 0);
      chk("t1_rel_hold", bus.hold, 0);
      tick();

      // burst limit, master 0 writes with the slave acking every cycle
      drive(0, 1, 1, 0, 32'h0000_0040, 32'hA5A5_0000);
      give(0);
      bus.s_ack = 1'b1;
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.m_ack[0]) cnt++;
         tick();
      end
      @(negedge clk);
      chk("t2_ack_count", cnt, 4);
      chk("t2_rel_cyc", bus.s_cyc, 0);
      tick();
      @(negedge clk);
      chk("t2_idle_hold", bus.hold, 0);
      tick();
      @(negedge clk);
      chk("t2_second_hold", bus.hold, 1);
      chk("t2_second_ack", bus.m_ack, 8'h01);
      tick();
      settle();

      // timeout, master 5, no ack
      drive(5, 1, 0, 1, 32'h5000_0000, 32'h0);
      give(5);
      tick();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk("t3_m_err", bus.m_err, (c == 8) ? 8'h20 : 8'h00);
         chk("t3_m_ack", bus.m_ack, 0);
         tick();
      end
      @(negedge clk);
      chk("t3_rel_cyc", bus.s_cyc, 0);
      settle();

      // ack exactly on the timeout boundary
      drive(5, 1, 0, 1, 32'h5000_0010, 32'h0);
      give(5);
      tick();
      for (int c = 1; c <= 8; c++) begin
         bus.s_ack = (c == 8);
         @(negedge clk);
         chk("t4_m_ack", bus.m_ack, (c == 8) ? 8'h20 : 8'h00);
         chk("t4_m_err", bus.m_err, 0);
         tick();
      end
      bus.s_ack = 1'b0;
      @(negedge clk);
      chk("t4_rel_cyc", bus.s_cyc, 0);
      settle();

      // ce stall mid-burst, then reset during ACTIVE
      drive(3, 1, 1, 0, 32'h3000_0000, 32'h3333_3333);
      give(3);
      tick();
      bus.s_ack = 1'b1;
      @(negedge clk);
      chk("t5_first_ack", bus.m_ack, 8'h08);
      tick();
      ce = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t5_stall_ack", bus.m_ack, 0);
         chk("t5_stall_err", bus.m_err, 0);
         chk("t5_stall_cyc", bus.s_cyc, 1);
         chk("t5_stall_adr", bus.s_adr, 32'h3000_0000);
         tick();
      end
      ce = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t5_resume_ack", bus.m_ack, 8'h08);
         tick();
      end
      bus.s_ack = 1'b0;
      @(negedge clk);
      chk("t5_limit_rel", bus.s_cyc, 0);
      tick();
      tick();
      @(negedge clk);
      chk("t5_reown_hold", bus.hold, 1);
      rst = 1'b1;
      bus.s_ack = 1'b1;
      #1;
      chk("t5_rst_no_ack", bus.m_ack, 0);
      tick();
      rst = 1'b0;
      clear();
      @(negedge clk);
      chk("t5_rst_hold", bus.hold, 0);
      chk("t5_rst_cyc", bus.s_cyc, 0);
      tick();

      // invalid grant encoding and grant without request
      drive(0, 1, 0, 0, 32'h0000_0100, 32'h0);
      bus.grant     = 8'h01;
      bus.grant_enc = 4'd8;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t6_bad_enc_hold", bus.hold, 0);
         tick();
      end
      bus.grant     = 8'h02;
      bus.grant_enc = 4'd1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("t6_noreq_hold", bus.hold, 0);
         tick();
      end
      clear();
      drive(6, 1, 0, 0, 32'h6000_0000, 32'h0);
      give(6);
      tick();
      @(negedge clk);
      chk("t6_act_stb", bus.s_stb, 1);
      tick();
      bus.m_req[6] = 1'b0;
      @(negedge clk);
      chk("t6_drop_stb", bus.s_stb, 0);
      chk("t6_drop_cyc", bus.s_cyc, 1);
      chk("t6_drop_ack", bus.m_ack, 0);
      chk("t6_drop_err", bus.m_err, 0);
      tick();
      @(negedge clk);
      chk("t6_drop_rel", bus.s_cyc, 0);
      settle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
